// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared constants for the PWM key controller: repeat FSM
//                state encoding, key bit indices and default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Auto-repeat FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_RPT  = 2'd2;

    // Bit positions inside key_n
    localparam int c_KEY_INC   = 0;
    localparam int c_KEY_DEC   = 1;
    localparam int c_KEY_SEL   = 2;
    localparam int c_KEY_APPLY = 3;

    // Default parameter values (timings assume a 50 MHz clock)
    localparam logic [24:0] c_REPEAT_DLY_DEF = 25'd24999999;
    localparam logic [24:0] c_REPEAT_PER_DEF = 25'd4999999;
    localparam logic [7:0]  c_DUTY_MAX_DEF   = 8'd250;
    localparam logic [5:0]  c_DEAD_MAX_DEF   = 6'd63;
    localparam logic [7:0]  c_DUTY_RST_DEF   = 8'd125;
    localparam logic [5:0]  c_DEAD_RST_DEF   = 6'd10;

endpackage
`default_nettype wire

// File: rtl/pwm_key_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_key_ctrl_if
//  Description : Key / PWM-control signal bundle of the PWM key controller.
//                slave = controller side, master = driver/observer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_key_ctrl_if;

    logic [3:0] key_n;
    logic       period_end;
    logic [7:0] duty;
    logic [5:0] dead;
    logic       sel;
    logic [7:0] disp_val;
    logic       pending;
    logic       upd;

    modport master (
        output key_n, period_end,
        input  duty, dead, sel, disp_val, pending, upd
    );

    modport slave (
        input  key_n, period_end,
        output duty, dead, sel, disp_val, pending, upd
    );

endinterface
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
//  Module      : key_edge
//  Description : 4-bit falling-edge (press) detector on active-low keys with
//                a registered previous value. Detection is held off for the
//                first cycle after reset so keys already down at reset
//                release must be released and pressed again.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_edge (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic [3:0] i_key_n,
    output logic      [3:0] o_press
);

    logic [3:0] r_prev;
    logic       r_armed;

    // Track previous key levels; arm detection one cycle after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev  <= 4'hF;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_key_n;
            r_armed <= 1'b1;
        end
    end

    assign o_press = r_armed ? (r_prev & ~i_key_n) : 4'h0;

endmodule
`default_nettype wire

// File: rtl/pwm_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_key_ctrl
//  Description : Key-driven editor for PWM duty and dead time. INC/DEC edit a
//                shadow register with press-and-hold auto-repeat, SEL picks
//                the target, APPLY copies the shadows into the active
//                registers at the next PWM period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_key_ctrl
    import pwm_pkg::*;
#(
    parameter logic [24:0] REPEAT_DLY = c_REPEAT_DLY_DEF,
    parameter logic [24:0] REPEAT_PER = c_REPEAT_PER_DEF,
    parameter logic [7:0]  DUTY_MAX   = c_DUTY_MAX_DEF,
    parameter logic [5:0]  DEAD_MAX   = c_DEAD_MAX_DEF,
    parameter logic [7:0]  DUTY_RST   = c_DUTY_RST_DEF,
    parameter logic [5:0]  DEAD_RST   = c_DEAD_RST_DEF
) (
    input  wire logic       clock,
    input  wire logic       reset,
    pwm_key_ctrl_if.slave   ctrl
);

    logic [3:0]  w_press;
    logic        w_apply_ev;
    logic        w_sel_ev;
    logic        w_inc_ev;
    logic        w_dec_ev;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [24:0] r_timer;
    logic [24:0] w_timer_nxt;
    logic [24:0] w_timer_inc;
    logic        r_dir;          // 0 = INC held, 1 = DEC held
    logic        w_dir_nxt;
    logic        w_step;
    logic        w_held_up;

    logic [7:0]  r_sh_duty;
    logic [5:0]  r_sh_dead;
    logic [7:0]  w_sh_duty_nxt;
    logic [5:0]  w_sh_dead_nxt;
    logic        r_sel;
    logic [7:0]  r_disp;

    logic [7:0]  r_duty;
    logic [5:0]  r_dead;
    logic        r_pending;
    logic        w_load;
    logic        r_load_q;
    logic        r_upd;

    key_edge u_key_edge (
        .clock   (clock),
        .reset   (reset),
        .i_key_n (ctrl.key_n),
        .o_press (w_press)
    );

    // Priority resolution of simultaneous presses: APPLY > SEL > INC > DEC
    always_comb begin
        w_apply_ev = w_press[c_KEY_APPLY];
        w_sel_ev   = w_press[c_KEY_SEL] & ~w_press[c_KEY_APPLY];
        w_inc_ev   = w_press[c_KEY_INC] & ~w_press[c_KEY_SEL] & ~w_press[c_KEY_APPLY];
        w_dec_ev   = w_press[c_KEY_DEC] & ~w_press[c_KEY_INC] & ~w_press[c_KEY_SEL]
                   & ~w_press[c_KEY_APPLY];
    end

    assign w_timer_inc = r_timer + 25'd1;
    assign w_held_up   = r_dir ? ctrl.key_n[c_KEY_DEC] : ctrl.key_n[c_KEY_INC];

    // Auto-repeat FSM: one step on the press, one after the hold delay,
    // then one per repeat period until the held key is released
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_inc_ev || w_dec_ev) begin
                    w_state_nxt = c_ST_HOLD;
                    w_timer_nxt = 25'd0;
                    w_dir_nxt   = w_dec_ev;
                    w_step      = 1'b1;
                end
            end
            c_ST_HOLD, c_ST_RPT: begin
                if (w_held_up || w_press[c_KEY_SEL] || w_press[c_KEY_APPLY]) begin
                    w_state_nxt = c_ST_IDLE;
                    w_timer_nxt = 25'd0;
                end else if (w_timer_inc == ((r_state == c_ST_HOLD) ? REPEAT_DLY : REPEAT_PER)) begin
                    w_state_nxt = c_ST_RPT;
                    w_timer_nxt = 25'd0;
                    w_step      = 1'b1;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_timer_nxt = 25'd0;
            end
        endcase
    end

    // Saturating step of the selected shadow register
    always_comb begin
        w_sh_duty_nxt = r_sh_duty;
        w_sh_dead_nxt = r_sh_dead;
        if (w_step) begin
            if (!r_sel) begin
                if (w_dir_nxt) begin
                    if (r_sh_duty != 8'd0) w_sh_duty_nxt = r_sh_duty - 8'd1;
                end else if (r_sh_duty < DUTY_MAX) begin
                    w_sh_duty_nxt = r_sh_duty + 8'd1;
                end
            end else begin
                if (w_dir_nxt) begin
                    if (r_sh_dead != 6'd0) w_sh_dead_nxt = r_sh_dead - 6'd1;
                end else if (r_sh_dead < DEAD_MAX) begin
                    w_sh_dead_nxt = r_sh_dead + 6'd1;
                end
            end
        end
    end

    // FSM state, repeat timer and held-key direction
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_timer <= 25'd0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Shadow registers, edit target and the registered display value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sh_duty <= DUTY_RST;
            r_sh_dead <= DEAD_RST;
            r_sel     <= 1'b0;
            r_disp    <= DUTY_RST;
        end else begin
            r_sh_duty <= w_sh_duty_nxt;
            r_sh_dead <= w_sh_dead_nxt;
            if (w_sel_ev) r_sel <= ~r_sel;
            r_disp    <= r_sel ? {2'b00, r_sh_dead} : r_sh_duty;
        end
    end

    assign w_load = r_pending & ctrl.period_end;

    // Deferred apply: shadows move to the active registers at period end;
    // upd follows the load by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_duty    <= DUTY_RST;
            r_dead    <= DEAD_RST;
            r_pending <= 1'b0;
            r_load_q  <= 1'b0;
            r_upd     <= 1'b0;
        end else begin
            r_load_q <= w_load;
            r_upd    <= r_load_q;
            if (w_load) begin
                r_duty    <= r_sh_duty;
                r_dead    <= r_sh_dead;
                r_pending <= 1'b0;
            end else if (w_apply_ev) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign ctrl.duty     = r_duty;
    assign ctrl.dead     = r_dead;
    assign ctrl.sel      = r_sel;
    assign ctrl.disp_val = r_disp;
    assign ctrl.pending  = r_pending;
    assign ctrl.upd      = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_pwm_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_key_ctrl
//  Description : Directed self-checking bench for pwm_key_ctrl with short
//                repeat timings (delay 10, period 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_key_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    pwm_key_ctrl_if bus ();

    pwm_key_ctrl #(
        .REPEAT_DLY (25'd10),
        .REPEAT_PER (25'd4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle key press followed by a release cycle
    task automatic press(input logic [3:0] kn);
        bus.key_n = kn;
        tick(1);
        bus.key_n = 4'hF;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_n      = 4'hF;
        bus.period_end = 1'b0;
        reset          = 1'b1;
        tick(2);
        chk("rst_duty", bus.duty, 125);
        chk("rst_dead", bus.dead, 10);
        chk("rst_sel", bus.sel, 0);
        chk("rst_disp", bus.disp_val, 125);
        chk("rst_pending", bus.pending, 0);
        chk("rst_upd", bus.upd, 0);
        reset = 1'b0;
        tick(1);

        // Single INC press held 3 cycles
        bus.key_n = 4'hE;
        tick(3);
        bus.key_n = 4'hF;
        tick(2);
        chk("inc1_disp", bus.disp_val, 126);
        chk("inc1_duty", bus.duty, 125);
        chk("inc1_pending", bus.pending, 0);

        // Auto-repeat: 30 cycles held -> steps at 0,10,14,18,22,26
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        bus.key_n = 4'hE;
        tick(12);
        chk("rpt_after_dly", bus.disp_val, 127);
        tick(4);
        chk("rpt_first_per", bus.disp_val, 128);
        tick(14);
        bus.key_n = 4'hF;
        tick(2);
        chk("rpt_final", bus.disp_val, 131);
        chk("rpt_duty", bus.duty, 125);

        // Key held across reset release gives no press
        bus.key_n = 4'hE;
        reset     = 1'b1;
        tick(1);
        reset     = 1'b0;
        tick(3);
        chk("held_rst_disp", bus.disp_val, 125);
        bus.key_n = 4'hF;
        tick(1);
        press(4'hE);
        chk("repress_disp", bus.disp_val, 126);

        // INC + APPLY together: only pending
        press(4'h6);
        chk("incapp_pending", bus.pending, 1);
        chk("incapp_disp", bus.disp_val, 126);

        // Edit while pending, second APPLY, then load
        press(4'hE);
        chk("pend_edit_disp", bus.disp_val, 127);
        chk("pend_edit_duty", bus.duty, 125);
        press(4'h7);
        chk("pend_reapply", bus.pending, 1);
        bus.period_end = 1'b1;
        tick(1);
        bus.period_end = 1'b0;
        chk("load_duty", bus.duty, 127);
        chk("load_pending", bus.pending, 0);
        chk("load_upd_early", bus.upd, 0);
        tick(1);
        chk("load_upd", bus.upd, 1);
        tick(1);
        chk("load_upd_end", bus.upd, 0);

        // APPLY in the same cycle as period_end
        press(4'hE);
        bus.key_n      = 4'h7;
        bus.period_end = 1'b1;
        tick(1);
        bus.key_n      = 4'hF;
        bus.period_end = 1'b0;
        chk("samecyc_pending", bus.pending, 1);
        chk("samecyc_duty", bus.duty, 127);
        tick(2);
        bus.period_end = 1'b1;
        tick(1);
        bus.period_end = 1'b0;
        chk("samecyc_load", bus.duty, 128);
        chk("samecyc_pend0", bus.pending, 0);
        tick(1);
        chk("samecyc_upd", bus.upd, 1);
        tick(1);
        chk("samecyc_upd_end", bus.upd, 0);

        // Dead-time edits and saturation
        press(4'hB);
        chk("sel_on", bus.sel, 1);
        chk("sel_disp", bus.disp_val, 10);
        bus.key_n = 4'hE;
        tick(211);
        bus.key_n = 4'hF;
        tick(2);
        chk("dead_62", bus.disp_val, 62);
        repeat (3) press(4'hE);
        chk("dead_sat_hi", bus.disp_val, 63);
        chk("dead_active", bus.dead, 10);
        bus.key_n = 4'hD;
        tick(300);
        bus.key_n = 4'hF;
        tick(2);
        chk("dead_down0", bus.disp_val, 0);
        press(4'hD);
        chk("dead_sat_lo", bus.disp_val, 0);

        // SEL beats INC
        press(4'hA);
        chk("selinc_sel", bus.sel, 0);
        chk("selinc_disp", bus.disp_val, 128);
        press(4'hB);
        press(4'h7);
        bus.period_end = 1'b1;
        tick(1);
        bus.period_end = 1'b0;
        chk("dead_load", bus.dead, 0);
        chk("dead_load_duty", bus.duty, 128);

        // Reset while pending abandons the load
        press(4'hE);
        press(4'h7);
        chk("rstpend_pending", bus.pending, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bus.period_end = 1'b1;
        tick(1);
        bus.period_end = 1'b0;
        chk("rstpend_duty", bus.duty, 125);
        chk("rstpend_dead", bus.dead, 10);
        chk("rstpend_pend", bus.pending, 0);
        tick(1);
        chk("rstpend_upd1", bus.upd, 0);
        tick(1);
        chk("rstpend_upd2", bus.upd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
